// File: rtl/dmem_arbiter_if.sv
// Purpose : bundles the two requester ports and the memory command port of dmem_arbiter.
// Latency : none; wires only.
// Backpres: requesters hold i_reqN until o_gntN; the arbiter side is the slave modport.
// Ports   : i_reqN/i_weN/i_addrN/i_wdataN in, o_gntN/o_doneN/o_rdataN out (N=0 CPU, 1 UART);
//           o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata out, i_mem_rdata in, o_busy out.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              i_req0;
  logic              i_req1;
  logic              i_we0;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata0;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic              o_done0;
  logic              o_done1;
  logic [DATA_W-1:0] o_rdata0;
  logic [DATA_W-1:0] o_rdata1;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_busy;

  // Arbiter side.
  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    input  i_mem_rdata,
    output o_gnt0, o_gnt1, o_done0, o_done1, o_rdata0, o_rdata1,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );

  // Requester / memory environment side.
  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1,
    output i_mem_rdata,
    input  o_gnt0, o_gnt1, o_done0, o_done1, o_rdata0, o_rdata1,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : round-robin arbiter/sequencer giving CPU (0) and UART loader (1) access to one
//           single-port data memory, one access at a time; all outputs registered.
// Latency : req in IDLE at cycle 0 -> gnt + mem_en cycle 1 -> done (+rdata) cycle 3; 1 access / 3 cycles.
// Backpres: a requester holds req until its gnt pulse; the loser stays pending untouched.
// Ports   : clk, rst (async, active-low); bus = dmem_arbiter_if.slave (requesters + memory port).
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  state_t            r_state, w_state_nx;
  logic              r_prio,      w_prio_nx;
  logic              r_owner,     w_owner_nx;
  logic              r_we,        w_we_nx;
  logic              r_gnt0,      w_gnt0_nx;
  logic              r_gnt1,      w_gnt1_nx;
  logic              r_done0,     w_done0_nx;
  logic              r_done1,     w_done1_nx;
  logic [DATA_W-1:0] r_rdata0,    w_rdata0_nx;
  logic [DATA_W-1:0] r_rdata1,    w_rdata1_nx;
  logic              r_mem_en,    w_mem_en_nx;
  logic              r_mem_we,    w_mem_we_nx;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nx;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nx;
  logic              r_busy,      w_busy_nx;

  logic w_any;
  logic w_win;

  assign w_any = bus.i_req0 | bus.i_req1;
  // A lone requester wins outright; on a tie the round-robin pointer decides.
  assign w_win = (bus.i_req0 & bus.i_req1) ? r_prio : bus.i_req1;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_prio      <= w_prio_nx;
      r_owner     <= w_owner_nx;
      r_we        <= w_we_nx;
      r_gnt0      <= w_gnt0_nx;
      r_gnt1      <= w_gnt1_nx;
      r_done0     <= w_done0_nx;
      r_done1     <= w_done1_nx;
      r_rdata0    <= w_rdata0_nx;
      r_rdata1    <= w_rdata1_nx;
      r_mem_en    <= w_mem_en_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nx = w_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_state_nx = ST_RESP;
      ST_RESP:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Next-output logic. Strobes default low so gnt, mem_en, mem_we and done are single-cycle;
  // mem_addr/mem_wdata double as the latched request and hold through RESP.
  always_comb begin
    w_prio_nx      = r_prio;
    w_owner_nx     = r_owner;
    w_we_nx        = r_we;
    w_gnt0_nx      = 1'b0;
    w_gnt1_nx      = 1'b0;
    w_done0_nx     = 1'b0;
    w_done1_nx     = 1'b0;
    w_rdata0_nx    = r_rdata0;
    w_rdata1_nx    = r_rdata1;
    w_mem_en_nx    = 1'b0;
    w_mem_we_nx    = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_owner_nx     = w_win;
          w_we_nx        = w_win ? bus.i_we1    : bus.i_we0;
          w_gnt0_nx      = ~w_win;
          w_gnt1_nx      = w_win;
          w_mem_en_nx    = 1'b1;
          w_mem_we_nx    = w_win ? bus.i_we1    : bus.i_we0;
          w_mem_addr_nx  = w_win ? bus.i_addr1  : bus.i_addr0;
          w_mem_wdata_nx = w_win ? bus.i_wdata1 : bus.i_wdata0;
        end
      end
      ST_RESP: begin
        // Memory read data is valid now, one cycle after the strobe in ISSUE.
        if (!r_we) begin
          if (r_owner) w_rdata1_nx = bus.i_mem_rdata;
          else         w_rdata0_nx = bus.i_mem_rdata;
        end
        w_done0_nx = ~r_owner;
        w_done1_nx = r_owner;
        w_prio_nx  = ~r_owner;
      end
      default: ;
    endcase
  end

  assign w_busy_nx = (w_state_nx == ST_ISSUE) || (w_state_nx == ST_RESP);

  assign bus.o_gnt0      = r_gnt0;
  assign bus.o_gnt1      = r_gnt1;
  assign bus.o_done0     = r_done0;
  assign bus.o_done1     = r_done1;
  assign bus.o_rdata0    = r_rdata0;
  assign bus.o_rdata1    = r_rdata1;
  assign bus.o_mem_en    = r_mem_en;
  assign bus.o_mem_we    = r_mem_we;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed self-checking bench for dmem_arbiter with a behavioural synchronous memory.
// Latency : n/a.
// Backpres: n/a.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory; a preload port lets the bench seed contents.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata     <= mem[bus.o_mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.i_req0 = 1'b0; bus.i_we0 = 1'b0; bus.i_addr0 = '0; bus.i_wdata0 = '0;
    bus.i_req1 = 1'b0; bus.i_we1 = 1'b0; bus.i_addr1 = '0; bus.i_wdata1 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   n_en;
    logic any1;
    logic prev_en;
    logic any_act;

    idle_inputs();
    rst = 1'b0;
    preload(5'd5, 32'hDEADBEEF);
    preload(5'd3, 32'h33333333);
    preload(5'd4, 32'h44444444);
    preload(5'd7, 32'h77777777);
    preload(5'd1, 32'hA1A1A1A1);
    preload(5'd2, 32'hB2B2B2B2);
    preload(5'd9, 32'h0);

    // Reset values.
    chk("rst_gnt0", bus.o_gnt0, 0);
    chk("rst_gnt1", bus.o_gnt1, 0);
    chk("rst_done0", bus.o_done0, 0);
    chk("rst_done1", bus.o_done1, 0);
    chk("rst_rdata0", bus.o_rdata0, 0);
    chk("rst_rdata1", bus.o_rdata1, 0);
    chk("rst_mem_en", bus.o_mem_en, 0);
    chk("rst_mem_we", bus.o_mem_we, 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    chk("rst_mem_wdata", bus.o_mem_wdata, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst = 1'b1;

    // CPU read of mem[5].
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 5'd5;
    chk("rd_c0_gnt0", bus.o_gnt0, 0);
    tick();
    chk("rd_c1_gnt0", bus.o_gnt0, 1);
    chk("rd_c1_mem_en", bus.o_mem_en, 1);
    chk("rd_c1_mem_we", bus.o_mem_we, 0);
    chk("rd_c1_mem_addr", bus.o_mem_addr, 5);
    chk("rd_c1_busy", bus.o_busy, 1);
    bus.i_req0 = 1'b0;
    tick();
    chk("rd_c2_gnt0", bus.o_gnt0, 0);
    chk("rd_c2_mem_en", bus.o_mem_en, 0);
    chk("rd_c2_done0", bus.o_done0, 0);
    chk("rd_c2_busy", bus.o_busy, 1);
    tick();
    chk("rd_c3_done0", bus.o_done0, 1);
    chk("rd_c3_rdata0", bus.o_rdata0, 32'hDEADBEEF);
    chk("rd_c3_rdata1", bus.o_rdata1, 0);
    chk("rd_c3_done1", bus.o_done1, 0);
    chk("rd_c3_busy", bus.o_busy, 0);
    tick();
    chk("rd_c4_done0", bus.o_done0, 0);
    chk("rd_c4_rdata0_hold", bus.o_rdata0, 32'hDEADBEEF);

    // UART write to addr 9, then CPU reads it back-to-back.
    bus.i_req1 = 1'b1; bus.i_we1 = 1'b1; bus.i_addr1 = 5'd9; bus.i_wdata1 = 32'h12345678;
    tick();
    chk("wr_c1_gnt1", bus.o_gnt1, 1);
    chk("wr_c1_gnt0", bus.o_gnt0, 0);
    chk("wr_c1_mem_we", bus.o_mem_we, 1);
    chk("wr_c1_mem_addr", bus.o_mem_addr, 9);
    chk("wr_c1_mem_wdata", bus.o_mem_wdata, 32'h12345678);
    bus.i_req1 = 1'b0; bus.i_we1 = 1'b0;
    tick();
    chk("wr_c2_mem_we", bus.o_mem_we, 0);
    tick();
    chk("wr_c3_done1", bus.o_done1, 1);
    chk("wr_c3_rdata1", bus.o_rdata1, 0);
    chk("wr_c3_mem9", mem[9], 32'h12345678);
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 5'd9;
    tick();
    chk("rb_c1_gnt0", bus.o_gnt0, 1);
    chk("rb_c1_mem_addr", bus.o_mem_addr, 9);
    bus.i_req0 = 1'b0;
    tick();
    tick();
    chk("rb_c3_done0", bus.o_done0, 1);
    chk("rb_c3_rdata0", bus.o_rdata0, 32'h12345678);
    tick();

    // Contention: both requesters held high from reset.
    rst = 1'b0;
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 5'd1;
    bus.i_req1 = 1'b1; bus.i_we1 = 1'b0; bus.i_addr1 = 5'd2;
    tick();
    tick();
    rst = 1'b1;
    prev_en = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("ct_c%0d_gnt0", c), bus.o_gnt0, (c == 1 || c == 7) ? 1 : 0);
      chk($sformatf("ct_c%0d_gnt1", c), bus.o_gnt1, (c == 4 || c == 10) ? 1 : 0);
      chk($sformatf("ct_c%0d_en_adj", c), prev_en & bus.o_mem_en, 0);
      chk($sformatf("ct_c%0d_done_excl", c), bus.o_done0 & bus.o_done1, 0);
      prev_en = bus.o_mem_en;
      if (c == 3)  chk("ct_c3_rdata0", bus.o_rdata0, 32'hA1A1A1A1);
      if (c == 6)  chk("ct_c6_rdata1", bus.o_rdata1, 32'hB2B2B2B2);
      if (c == 12) begin
        chk("ct_c12_done1", bus.o_done1, 1);
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
      end
    end
    tick();
    chk("ct_c13_busy", bus.o_busy, 0);

    // Withdrawal: req1 pulses while req0 is in ISSUE.
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 5'd4;
    n_en = 0;
    any1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_en += int'(bus.o_mem_en);
      any1 |= bus.o_gnt1 | bus.o_done1;
      if (c == 1) begin
        chk("wd_c1_gnt0", bus.o_gnt0, 1);
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b1; bus.i_addr1 = 5'd6;
      end
      if (c == 2) bus.i_req1 = 1'b0;
      if (c == 3) chk("wd_c3_rdata0", bus.o_rdata0, 32'h44444444);
    end
    chk("wd_en_count", n_en, 1);
    chk("wd_req1_quiet", any1, 0);

    // Input change after grant.
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 5'd3;
    tick();
    chk("ic_c1_mem_addr", bus.o_mem_addr, 3);
    bus.i_addr0 = 5'd7;
    bus.i_req0 = 1'b0;
    tick();
    chk("ic_c2_mem_addr", bus.o_mem_addr, 3);
    tick();
    chk("ic_c3_done0", bus.o_done0, 1);
    chk("ic_c3_rdata0", bus.o_rdata0, 32'h33333333);
    tick();

    // Reset asserted during ISSUE.
    bus.i_req0 = 1'b1; bus.i_we0 = 1'b0; bus.i_addr0 = 5'd5;
    tick();
    chk("ri_c1_gnt0", bus.o_gnt0, 1);
    rst = 1'b0;
    #1;
    chk("ri_gnt0", bus.o_gnt0, 0);
    chk("ri_mem_en", bus.o_mem_en, 0);
    chk("ri_mem_addr", bus.o_mem_addr, 0);
    chk("ri_busy", bus.o_busy, 0);
    chk("ri_rdata0", bus.o_rdata0, 0);
    bus.i_req0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    any_act = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      any_act |= bus.o_done0 | bus.o_done1 | bus.o_gnt0 | bus.o_gnt1 | bus.o_mem_en | bus.o_busy;
    end
    chk("ri_no_activity", any_act, 0);
    // Priority back at 0: a tie goes to requester 0.
    bus.i_req0 = 1'b1; bus.i_addr0 = 5'd1;
    bus.i_req1 = 1'b1; bus.i_addr1 = 5'd2;
    tick();
    chk("ri_tie_gnt0", bus.o_gnt0, 1);
    chk("ri_tie_gnt1", bus.o_gnt1, 0);
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    tick();
    tick();
    chk("ri_tie_done0", bus.o_done0, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and sequencer for the shared single-port data memory. It sits between the CPU memory stage (requester 0) and the UART debug loader (requester 1), and drives the memory's command port. It serialises their read and write requests into one memory access at a time, returns read data, and pulses a per-requester completion strobe. All outputs are registered.

## Interface
- ADDR_W, 5: word address width; memory depth is 2^ADDR_W words.
- DATA_W, 32: data word width.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req0 / i_req1  in  1  access request from CPU / UART; held until grant.
- i_we0 / i_we1  in  1  1 = write, 0 = read; qualified by req.
- i_addr0 / i_addr1  in  ADDR_W  word address.
- i_wdata0 / i_wdata1  in  DATA_W  write data.
- o_gnt0 / o_gnt1  out  1  one-cycle grant pulse; request is consumed.
- o_done0 / o_done1  out  1  one-cycle completion pulse.
- o_rdata0 / o_rdata1  out  DATA_W  read result; valid with done, held until the next read completes for that port.
- o_mem_en  out  1  memory access strobe.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_rdata  in  DATA_W  memory read data; synchronous, valid the cycle after o_mem_en.
- o_busy  out  1  high in ISSUE and RESP.

## Operation
- FSM states:
  - IDLE (2'b00)
  - ISSUE (2'b01)
  - RESP (2'b10)
  - Code 2'b11 is illegal and goes to IDLE.
- Round-robin pointer `prio`: 0 favours requester 0. Reset value is 0.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick a winner: the single requester asserting req, or `prio` when both assert.
  - At the edge:
    - latch owner, we, addr and wdata from the winner's inputs;
    - set the winner's o_gnt to 1;
    - load o_mem_en=1 and o_mem_we/o_mem_addr/o_mem_wdata from the winner;
    - go to ISSUE.
- ISSUE (exactly 1 cycle):
  - The memory command and o_gnt are visible.
  - At the edge: clear o_gnt, o_mem_en and o_mem_we; go to RESP.
  - o_mem_addr and o_mem_wdata hold their values.
- RESP (exactly 1 cycle): at the edge,
  - for a read, o_rdata[owner] <= i_mem_rdata; for a write, o_rdata is unchanged;
  - o_done[owner] <= 1;
  - prio <= ~owner;
  - go to IDLE.
- o_done clears at the next edge.
- Requester inputs are sampled only at the IDLE decision edge. They may change freely after o_gnt rises.
- A req dropped before its grant is treated as withdrawn; no access occurs.
- The losing requester's req stays pending with no side effects.
- Reset values of all outputs are 0: both o_gnt, both o_done, both o_rdata, all o_mem_* outputs, and o_busy.
- Reset state is IDLE, prio=0.
- Reset asserted mid-operation:
  - outputs clear immediately (asynchronously);
  - the in-flight access is abandoned and no done pulse is issued;
  - a write already strobed in ISSUE may have committed.

## Timing
- Request-to-done latency, no contention: req high in IDLE at cycle 0 → gnt and mem_en in cycle 1 → RESP in cycle 2 → done and rdata in cycle 3.
- Throughput: one access per 3 cycles.
- Back-to-back: a req still high in the done cycle (IDLE) is arbitrated in that same cycle.
  - With both requesters continuously requesting, grants alternate 0,1,0,1…
  - Each requester waits at most 3 extra cycles.
- o_mem_en is never high for two consecutive cycles.
- At most one o_gnt and one o_done are high in any cycle.
- o_busy = (state==ISSUE)||(state==RESP), registered alongside state.

## Test plan
- CPU read, mem[5]=32'hDEADBEEF: i_req0=1, we0=0, addr0=5 at cycle 0 → o_gnt0, o_mem_en=1, o_mem_addr=5 at cycle 1; o_done0=1 and o_rdata0=32'hDEADBEEF at cycle 3; o_rdata1 stays 0.
- UART write then read: req1 writes 32'h12345678 to addr 9 → o_mem_we=1, o_mem_wdata=32'h12345678 in ISSUE, o_done1 three cycles after req; a subsequent read of addr 9 by req0 returns 32'h12345678.
- Contention: i_req0 and i_req1 both held high from reset → grants 0,1,0,1 on cycles 1,4,7,10; o_mem_en never high on adjacent cycles.
- Withdrawal: req1 pulses for one cycle while req0 is in ISSUE → no o_gnt1, no o_done1, no extra memory access.
- Input change after grant: addr0 changes from 3 to 7 in the ISSUE cycle → o_mem_addr stays 3; data returned is mem[3].
- Reset in ISSUE: rst=0 during an access → all outputs 0 immediately; after release, state is IDLE, prio=0, and no o_done pulse is produced.
